// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one external combinational 32-bit ALU between two
// requesters, filters unimplemented opcodes and returns tagged results on one response channel.
module alu_rr_scheduler #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter bit          PRIO_INIT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_sel,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_sel,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_y,
    output logic        rsp_cout,
    output logic        rsp_neg,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_cin,
    input  logic [31:0] alu_y,
    input  logic        alu_cout,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q, illegal_q;
    logic [31:0] alu_a_q, alu_b_q;
    logic [3:0]  alu_sel_q;
    logic        alu_cin_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_y_q;
    logic        rsp_cout_q, rsp_neg_q, rsp_zero_q, rsp_ovf_q, rsp_err_q;

    logic        any_req, grant, accept, capture;
    logic [31:0] g_a, g_b;
    logic [3:0]  g_sel;
    logic        g_cin, g_illegal;

    // With a single requester the grant follows it; prio only breaks ties.
    always_comb begin
        any_req   = req0_valid | req1_valid;
        grant     = (req0_valid & req1_valid) ? prio_q : req1_valid;
        g_a       = grant ? req1_a   : req0_a;
        g_b       = grant ? req1_b   : req0_b;
        g_sel     = grant ? req1_sel : req0_sel;
        g_cin     = grant ? req1_cin : req0_cin;
        g_illegal = (g_sel == 4'b1001) | (g_sel == 4'b1110) | (g_sel == 4'b1111);
        accept    = (state_q == StIdle) & any_req;
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    cnt_d   = CntLoad;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture     = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    prio_d      = ~id_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prio_q      <= PRIO_INIT;
            cnt_q       <= 4'd0;
            id_q        <= 1'b0;
            illegal_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                id_q      <= grant;
                illegal_q <= g_illegal;
                alu_a_q   <= g_a;
                alu_b_q   <= g_b;
                alu_sel_q <= g_illegal ? 4'b0000 : g_sel;
                alu_cin_q <= g_cin;
            end
            // Illegal opcodes report a zeroed result rather than whatever opcode 0 produced.
            if (capture) begin
                rsp_y_q    <= illegal_q ? 32'd0 : alu_y;
                rsp_cout_q <= ~illegal_q & alu_cout;
                rsp_neg_q  <= ~illegal_q & alu_negative;
                rsp_zero_q <= ~illegal_q & alu_zero;
                rsp_ovf_q  <= ~illegal_q & alu_overflow;
                rsp_err_q  <= illegal_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_cin   = alu_cin_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with a small behavioural ALU attached.
module tb_alu_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err;
    logic [31:0] rsp_y, alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic        alu_cin;
    logic [31:0] m_y;
    logic        m_cout, m_neg, m_zero, m_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.EXEC_CYCLES(1), .PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_y(m_y), .alu_cout(m_cout), .alu_negative(m_neg), .alu_zero(m_zero),
        .alu_overflow(m_ovf)
    );

    // External ALU: 0110 add with carry-in, 0111 subtract, 0000 AND, anything else passes A.
    always_comb begin
        logic [32:0] sum;
        logic [31:0] bop;
        sum    = '0;
        bop    = alu_b;
        m_y    = alu_a;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
        case (alu_sel)
            4'b0110: begin
                sum    = {1'b0, alu_a} + {1'b0, bop} + {32'd0, alu_cin};
                m_y    = sum[31:0];
                m_cout = sum[32];
                m_ovf  = (alu_a[31] == bop[31]) && (m_y[31] != alu_a[31]);
            end
            4'b0111: begin
                bop    = ~alu_b;
                sum    = {1'b0, alu_a} + {1'b0, bop} + 33'd1;
                m_y    = sum[31:0];
                m_cout = sum[32];
                m_ovf  = (alu_a[31] == bop[31]) && (m_y[31] != alu_a[31]);
            end
            4'b0000: m_y = alu_a & alu_b;
            default: m_y = alu_a;
        endcase
        m_neg  = m_y[31];
        m_zero = (m_y == 32'd0);
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic        cin;
        logic [31:0] y;
        logic        cout;
        logic        neg;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [3:0]  asel;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request at a negedge, wait for its grant, drop valid after the accept edge.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic cin);
        int n;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("grant", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        check("other_ready_low", {31'd0, (id ? req0_ready : req1_ready)}, 32'd0);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until rsp_valid rises.
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rsp_valid && n < 50);
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid low after %0d cycles, expected high", n);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int served;
        int both_hi;
        logic [1:0] order;
        vecs[0] = '{1'b0, 32'd5, 32'd3, 4'b0110, 1'b0, 32'd8,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[1] = '{1'b1, 32'd3, 32'd5, 4'b0111, 1'b0, 32'hFFFF_FFFE,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111};
        vecs[2] = '{1'b0, 32'h0000_00F0, 32'h0000_00FF, 4'b1001, 1'b0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[3] = '{1'b1, 32'h7FFF_FFFF, 32'd0, 4'b0110, 1'b1, 32'h8000_0000,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0, 32'd0,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 4'b1111, 1'b0, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{1'b0, 32'h8000_0001, 32'd1, 4'b1110, 1'b1, 32'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_y", rsp_y, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_sel", {28'd0, alu_sel}, 32'd0);

        // Contention straight after reset: PRIO_INIT=0 so order is 0,1,0,1.
        req0_a = 32'd1;  req0_b = 32'd1;  req0_sel = 4'b0110;
        req1_a = 32'd10; req1_b = 32'd20; req1_sel = 4'b0110;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        served = 0; both_hi = 0;
        for (int c = 0; c < 60 && served < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_hi++;
            if (rsp_valid) begin
                order = 2'(served);
                check("contention_id", {31'd0, rsp_id}, {31'd0, order[0]});
                check("contention_y", rsp_y, order[0] ? 32'd30 : 32'd2);
                served++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("contention_served", served, 32'd4);
        check("contention_both_ready", both_hi, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin);
            wait_rsp(n);
            check("latency", n, 32'd2);
            check("rsp_id", {31'd0, rsp_id}, {31'd0, vecs[i].id});
            check("rsp_y", rsp_y, vecs[i].y);
            check("rsp_cout", {31'd0, rsp_cout}, {31'd0, vecs[i].cout});
            check("rsp_neg", {31'd0, rsp_neg}, {31'd0, vecs[i].neg});
            check("rsp_zero", {31'd0, rsp_zero}, {31'd0, vecs[i].zero});
            check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, vecs[i].ovf});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, vecs[i].err});
            check("alu_sel", {28'd0, alu_sel}, {28'd0, vecs[i].asel});
            check("alu_a_held", alu_a, vecs[i].a);
            finish_rsp();
        end

        // Backpressure: response held for 5 cycles while requester 1 waits.
        issue(1'b0, 32'd2, 32'd2, 4'b0110, 1'b0);
        wait_rsp(n);
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_sel = 4'b0110; req1_cin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rsp_y", rsp_y, 32'd4);
            check("stall_rsp_id", {31'd0, rsp_id}, 32'd0);
            check("stall_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("release_idle_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(n);
        check("after_stall_id", {31'd0, rsp_id}, 32'd1);
        check("after_stall_y", rsp_y, 32'd15);
        finish_rsp();

        // Complete a requester-0 op so prio moves to 1, then reset mid-EXEC.
        issue(1'b0, 32'd100, 32'd1, 4'b0110, 1'b0);
        wait_rsp(n);
        check("pre_reset_y", rsp_y, 32'd101);
        finish_rsp();
        issue(1'b0, 32'd9, 32'd9, 4'b0110, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_exec_rsp_y", rsp_y, 32'd0);
        check("rst_exec_alu_a", alu_a, 32'd0);
        check("rst_exec_alu_sel", {28'd0, alu_sel}, 32'd0);
        check("rst_exec_alu_cin", {31'd0, alu_cin}, 32'd0);
        both_hi = 0;
        rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) both_hi++;
        end
        rsp_ready = 1'b0;
        check("rst_exec_no_rsp", both_hi, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_prio_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("rst_prio_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(n);
        check("rst_prio_rsp_id", {31'd0, rsp_id}, 32'd0);
        finish_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
